// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - signed filter x ifmap multiply-accumulate with read strobes and psum handshake
module conv_mac #(
    parameter int FILTER_SIZE = 16,
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     filter_full,
    input  logic                     ifmap_full,
    input  logic [DATA_W-1:0]        filter_byte,
    input  logic [DATA_W-1:0]        ifmap_byte,
    output logic                     filter_re,
    output logic                     ifmap_re,
    output logic                     buf_rst,
    output logic signed [ACC_W-1:0]  psum,
    output logic                     psum_valid,
    input  logic                     psum_ready,
    output logic                     busy
);

    localparam int CNT_W  = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state;
    logic [CNT_W-1:0]        tap;
    logic                    drain_cnt;
    logic                    accept;
    logic                    last_tap;
    logic                    byte_valid;
    logic                    prod_valid;
    logic signed [PROD_W-1:0] filter_ext;
    logic signed [PROD_W-1:0] ifmap_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;

    assign accept   = (state == S_IDLE) && start && filter_full && ifmap_full;
    assign last_tap = (tap == CNT_W'(FILTER_SIZE - 1));

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign filter_re  = (state == S_RUN);
    assign ifmap_re   = filter_re;
    assign buf_rst    = filter_re && (tap == '0);
    assign psum_valid = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign psum       = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tap       <= '0;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_RUN;
                        tap   <= '0;
                    end
                end
                S_RUN: begin
                    tap <= tap + 1'b1;
                    if (last_tap) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt)
                        state <= S_DONE;
                end
                default: begin
                    if (psum_ready)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    // Operands are widened first so the product is computed at full signed width.
    assign filter_ext = {{DATA_W{filter_byte[DATA_W-1]}}, filter_byte};
    assign ifmap_ext  = {{DATA_W{ifmap_byte[DATA_W-1]}}, ifmap_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_valid <= 1'b0;
            prod_valid <= 1'b0;
            prod       <= '0;
            acc        <= '0;
        end else begin
            byte_valid <= filter_re;
            prod_valid <= byte_valid;
            prod       <= filter_ext * ifmap_ext;
            if (accept)
                acc <= '0;
            else if (prod_valid)
                acc <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

endmodule

// File: tb/tb_conv_mac.sv
// tb/tb_conv_mac.sv - directed bench for conv_mac
module tb_conv_mac;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              filter_full;
    logic              ifmap_full;
    logic [7:0]        filter_byte;
    logic [7:0]        ifmap_byte;
    logic              filter_re;
    logic              ifmap_re;
    logic              buf_rst;
    logic signed [19:0] psum;
    logic              psum_valid;
    logic              psum_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] fmem [16];
    logic [7:0] imem [16];
    int rd_idx = 0;

    conv_mac #(.FILTER_SIZE(16), .DATA_W(8), .ACC_W(20)) dut (
        .clk(clk), .rst(rst), .start(start),
        .filter_full(filter_full), .ifmap_full(ifmap_full),
        .filter_byte(filter_byte), .ifmap_byte(ifmap_byte),
        .filter_re(filter_re), .ifmap_re(ifmap_re), .buf_rst(buf_rst),
        .psum(psum), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Buffer model: registered byte pair one cycle after the strobe, pointer zeroed by buf_rst.
    always @(posedge clk) begin
        if (filter_re) begin
            filter_byte <= fmem[buf_rst ? 0 : rd_idx];
            ifmap_byte  <= imem[buf_rst ? 0 : rd_idx];
            rd_idx      <= buf_rst ? 1 : (rd_idx + 1) % 16;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int f0, input int fstep, input int i0, input int istep);
        for (int i = 0; i < 16; i++) begin
            fmem[i] = 8'(f0 + fstep * i);
            imem[i] = 8'(i0 + istep * i);
        end
    endtask

    // Runs one window with psum_ready high, starting from IDLE; reports what it observed.
    task automatic run_window(output int n_re, output int n_brst, output int brst_cyc,
                              output int first_valid, output int n_valid, output int re_diff,
                              output logic signed [19:0] sum, output logic busy20);
        n_re = 0; n_brst = 0; brst_cyc = -1; first_valid = -1; n_valid = 0; re_diff = 0;
        sum = '0; busy20 = 1'bx;
        start = 1'b1; filter_full = 1'b1; ifmap_full = 1'b1; psum_ready = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (filter_re) n_re++;
            if (ifmap_re !== filter_re) re_diff++;
            if (buf_rst) begin n_brst++; brst_cyc = c; end
            if (psum_valid) begin
                n_valid++;
                if (first_valid < 0) begin first_valid = c; sum = psum; end
            end
            if (c == 20) busy20 = busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; filter_full = 1'b0; ifmap_full = 1'b0; psum_ready = 1'b0;
        load(0, 0, 0, 0);
        tick(); tick();
        checks++;
        if ({filter_re, ifmap_re, buf_rst, psum_valid, busy} !== 5'b0 || psum !== 20'sd0) begin
            errors++;
            $display("FAIL reset_outputs got strobes/valid/busy=%b psum=%0d want 0/0", {filter_re, ifmap_re, buf_rst, psum_valid, busy}, psum);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_ones();
        int n_re, n_brst, brst_cyc, fv, nv, rd; logic signed [19:0] s; logic b20;
        load(1, 0, 1, 0);
        run_window(n_re, n_brst, brst_cyc, fv, nv, rd, s, b20);
        checks++; if (s !== 20'sd16) begin errors++; $display("FAIL ones_psum got %0d want 16", s); end
        checks++; if (fv !== 19) begin errors++; $display("FAIL ones_valid_cycle got %0d want 19", fv); end
        checks++; if (nv !== 1) begin errors++; $display("FAIL ones_valid_len got %0d want 1", nv); end
        checks++; if (n_re !== 16) begin errors++; $display("FAIL ones_strobes got %0d want 16", n_re); end
        checks++; if (rd !== 0) begin errors++; $display("FAIL ones_re_match got %0d want 0", rd); end
        checks++; if (n_brst !== 1 || brst_cyc !== 1) begin errors++; $display("FAIL ones_buf_rst got n=%0d cyc=%0d want n=1 cyc=1", n_brst, brst_cyc); end
        checks++; if (b20 !== 1'b0) begin errors++; $display("FAIL ones_busy20 got %b want 0", b20); end
    endtask

    task automatic test_extremes();
        int n_re, n_brst, brst_cyc, fv, nv, rd; logic signed [19:0] s; logic b20;
        load(-128, 0, -128, 0);
        run_window(n_re, n_brst, brst_cyc, fv, nv, rd, s, b20);
        checks++; if (s !== 20'sd262144) begin errors++; $display("FAIL neg_neg_psum got %0d want 262144", s); end
        load(-128, 0, 127, 0);
        run_window(n_re, n_brst, brst_cyc, fv, nv, rd, s, b20);
        checks++; if (s !== -20'sd260096) begin errors++; $display("FAIL neg_pos_psum got %0d want -260096", s); end
    endtask

    task automatic test_ramp();
        int n_re, n_brst, brst_cyc, fv, nv, rd; logic signed [19:0] s; logic b20;
        load(0, 1, -8, 1);
        run_window(n_re, n_brst, brst_cyc, fv, nv, rd, s, b20);
        // sum i*(i-8), i=0..15 = 1240 - 960
        checks++; if (s !== 20'sd280) begin errors++; $display("FAIL ramp_psum got %0d want 280", s); end
    endtask

    task automatic test_backpressure();
        int vcyc = -1; logic signed [19:0] p = '0;
        load(1, 0, 1, 0);
        start = 1'b1; filter_full = 1'b1; ifmap_full = 1'b1; psum_ready = 1'b0;
        for (int c = 1; c <= 30 && vcyc < 0; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (psum_valid) begin vcyc = c; p = psum; end
        end
        checks++; if (vcyc !== 19) begin errors++; $display("FAIL bp_valid_cycle got %0d want 19", vcyc); end
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (psum_valid !== 1'b1 || psum !== 20'sd16 || filter_re !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold got valid=%b psum=%0d re=%b busy=%b want 1 16 0 1", psum_valid, psum, filter_re, busy);
            end
        end
        start = 1'b0; psum_ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || psum_valid !== 1'b0 || psum !== 20'sd16) begin
            errors++;
            $display("FAIL bp_release got busy=%b valid=%b psum=%0d want 0 0 16", busy, psum_valid, psum);
        end
    endtask

    task automatic test_async_reset();
        int n_re, n_brst, brst_cyc, fv, nv, rd; logic signed [19:0] s; logic b20;
        load(1, 0, 1, 0);
        start = 1'b1; filter_full = 1'b1; ifmap_full = 1'b1; psum_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) start = 1'b0;
        end
        checks++; if (filter_re !== 1'b1) begin errors++; $display("FAIL rst_pre_run got re=%b want 1", filter_re); end
        rst = 1'b1;
        #1;
        checks++;
        if ({filter_re, ifmap_re, buf_rst, psum_valid, busy} !== 5'b0 || psum !== 20'sd0) begin
            errors++;
            $display("FAIL rst_async got strobes/valid/busy=%b psum=%0d want 0/0", {filter_re, ifmap_re, buf_rst, psum_valid, busy}, psum);
        end
        tick();
        rst = 1'b0;
        tick();
        load(0, 1, -8, 1);
        run_window(n_re, n_brst, brst_cyc, fv, nv, rd, s, b20);
        checks++; if (s !== 20'sd280) begin errors++; $display("FAIL rst_resume_psum got %0d want 280", s); end
        checks++; if (n_brst !== 1 || brst_cyc !== 1 || n_re !== 16) begin errors++; $display("FAIL rst_resume_strobes got brst=%0d@%0d re=%0d want 1@1 16", n_brst, brst_cyc, n_re); end
    endtask

    task automatic test_gating();
        int n_re = 0, n_busy = 0;
        logic done = 1'b0;
        load(2, 0, 3, 0);
        start = 1'b1; filter_full = 1'b1; ifmap_full = 1'b0; psum_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (filter_re) n_re++;
            if (busy) n_busy++;
        end
        checks++; if (n_re !== 0 || n_busy !== 0) begin errors++; $display("FAIL gate_idle got re=%0d busy=%0d want 0 0", n_re, n_busy); end
        ifmap_full = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || buf_rst !== 1'b1) begin errors++; $display("FAIL gate_accept got busy=%b buf_rst=%b want 1 1", busy, buf_rst); end
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (psum_valid) begin
                done = 1'b1;
                checks++; if (psum !== 20'sd96) begin errors++; $display("FAIL gate_psum got %0d want 96", psum); end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gate_timeout got no psum_valid want psum_valid"); end
        tick();
    endtask

    task automatic test_back_to_back();
        int brst_cyc [$]; int valid_cyc [$];
        load(1, 0, -1, 0);
        start = 1'b1; filter_full = 1'b1; ifmap_full = 1'b1; psum_ready = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            tick();
            if (c == 39) start = 1'b0;
            if (buf_rst) brst_cyc.push_back(c);
            if (psum_valid) begin
                valid_cyc.push_back(c);
                checks++; if (psum !== -20'sd16) begin errors++; $display("FAIL b2b_psum got %0d want -16", psum); end
            end
        end
        checks++;
        if (brst_cyc.size() != 2) begin
            errors++; $display("FAIL b2b_windows got %0d want 2", brst_cyc.size());
        end else if (brst_cyc[0] != 1 || brst_cyc[1] != 21) begin
            errors++; $display("FAIL b2b_spacing got %0d,%0d want 1,21", brst_cyc[0], brst_cyc[1]);
        end
        checks++;
        if (valid_cyc.size() != 2) begin
            errors++; $display("FAIL b2b_valid got %0d want 2", valid_cyc.size());
        end else if (valid_cyc[0] != 19 || valid_cyc[1] != 39) begin
            errors++; $display("FAIL b2b_valid_cycles got %0d,%0d want 19,39", valid_cyc[0], valid_cyc[1]);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_extremes();
        test_ramp();
        test_backpressure();
        test_async_reset();
        test_gating();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
